// File: rtl/holy_core_pkg.sv
// Shared types and defaults for the core's memory-port arbiter.
package holy_core_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        ARB_OWNER_NONE = 2'd0,
        ARB_OWNER_I    = 2'd1,
        ARB_OWNER_D    = 2'd2
    } arb_owner_t;

    localparam int ARB_MAX_D_STREAK_DEF   = 4;
    localparam int ARB_TIMEOUT_CYCLES_DEF = 255;

    // Wide enough for the largest legal streak limit (15).
    localparam int ARB_STREAK_W = 4;

    function automatic logic [ARB_STREAK_W-1:0] streak_next(input logic [ARB_STREAK_W-1:0] s);
        return (s == '1) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the memory-port arbiter.
// master = the arbiter's view, slave = the core/memory environment's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_valid;
    logic              i_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [BE_W-1:0]   m_be;
    logic              m_gnt;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic              bus_err;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  m_gnt, m_rvalid, m_rdata,
        output i_rdata, i_valid, i_stall,
        output d_rdata, d_valid, d_stall,
        output m_req, m_we, m_addr, m_wdata, m_be,
        output bus_err
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output m_gnt, m_rvalid, m_rdata,
        input  i_rdata, i_valid, i_stall,
        input  d_rdata, d_valid, d_stall,
        input  m_req, m_we, m_addr, m_wdata, m_be,
        input  bus_err
    );

endinterface

// File: rtl/arb_watchdog.sv
// Saturating cycle counter for the arbiter's transaction watchdog; expire is high
// during the LIMIT-th consecutive enabled cycle since the last clear.
module arb_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int            CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between fetch and load/store: data priority
// with a fetch anti-starvation streak limit. Optional watchdog abort: HOLY_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import holy_core_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_D_STREAK   = ARB_MAX_D_STREAK_DEF,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES_DEF
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.master bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ARB_STREAK_W-1:0] STREAK_LIMIT = ARB_STREAK_W'(MAX_D_STREAK);

    arb_state_t              state;
    arb_owner_t              owner;
    logic [ARB_STREAK_W-1:0] streak;

    logic              m_req_q;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [BE_W-1:0]   m_be_q;

    logic              accept;
    logic              complete;
    logic              abort;
    logic              respond;
    logic              grant_d;
    logic              grant_i;
    logic [DATA_W-1:0] resp_data;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        accept   = 1'b0;
        complete = 1'b0;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        case (state)
            ARB_IDLE: begin
                grant_d = bus.d_req && (!bus.i_req || (streak < STREAK_LIMIT));
                grant_i = !grant_d && bus.i_req;
            end
            ARB_ISSUE: begin
                accept   = bus.m_gnt;
                complete = bus.m_gnt && bus.m_rvalid;
            end
            ARB_WAIT: begin
                complete = bus.m_rvalid;
            end
            default: begin
            end
        endcase
    end

`ifdef HOLY_ARB_TIMEOUT_EN
    logic wd_expire;

    arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == ARB_IDLE),
        .enable (state != ARB_IDLE),
        .expire (wd_expire)
    );

    // A response arriving in the expiry cycle still wins over the abort.
    assign abort       = wd_expire && !complete;
    assign bus.bus_err = abort && !rst;
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
    assign abort                 = 1'b0;
    assign bus.bus_err           = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            owner     <= ARB_OWNER_NONE;
            streak    <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_be_q    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        state     <= ARB_ISSUE;
                        owner     <= ARB_OWNER_D;
                        m_req_q   <= 1'b1;
                        m_we_q    <= bus.d_we;
                        m_addr_q  <= bus.d_addr;
                        m_wdata_q <= bus.d_wdata;
                        m_be_q    <= bus.d_we ? bus.d_be : '1;
                        // The streak only grows while fetch is actually being held off.
                        streak    <= bus.i_req ? streak_next(streak) : '0;
                    end else if (grant_i) begin
                        state     <= ARB_ISSUE;
                        owner     <= ARB_OWNER_I;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= bus.i_addr;
                        m_wdata_q <= '0;
                        m_be_q    <= '1;
                        streak    <= '0;
                    end
                end
                ARB_ISSUE: begin
                    if (complete || abort) begin
                        state   <= ARB_IDLE;
                        owner   <= ARB_OWNER_NONE;
                        m_req_q <= 1'b0;
                    end else if (accept) begin
                        state   <= ARB_WAIT;
                        m_req_q <= 1'b0;
                    end
                end
                ARB_WAIT: begin
                    if (complete || abort) begin
                        state <= ARB_IDLE;
                        owner <= ARB_OWNER_NONE;
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    owner   <= ARB_OWNER_NONE;
                    m_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Responses are pulsed in the m_rvalid cycle itself, so valid/rdata bypass the registers.
    assign respond   = (complete || abort) && !rst;
    assign resp_data = abort ? '0 : bus.m_rdata;

    assign bus.i_valid = respond && (owner == ARB_OWNER_I);
    assign bus.d_valid = respond && (owner == ARB_OWNER_D);
    assign bus.i_rdata = resp_data;
    assign bus.d_rdata = resp_data;
    assign bus.i_stall = bus.i_req && !bus.i_valid;
    assign bus.d_stall = bus.d_req && !bus.d_valid;

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_be    = m_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import holy_core_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MAX_D  = 4;
    localparam int TMO    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .MAX_D_STREAK   (MAX_D),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory side: manual drive for directed handshakes, or an auto responder
    // that grants immediately and answers one cycle later.
    logic        man_mode = 1'b1, man_gnt = 1'b0, man_rv = 1'b0;
    logic [31:0] man_rdata = '0;
    logic        auto_gnt = 1'b0, auto_rv = 1'b0, auto_pend = 1'b0;
    logic [31:0] auto_rdata = '0, auto_addr = '0;

    assign bus.m_gnt    = man_mode ? man_gnt   : auto_gnt;
    assign bus.m_rvalid = man_mode ? man_rv    : auto_rv;
    assign bus.m_rdata  = man_mode ? man_rdata : auto_rdata;

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return (a == 32'h100) ? 32'h00500093 : (a ^ 32'hA5A5_0000);
    endfunction

    always begin
        @(posedge clk);
        #1;
        auto_gnt = 1'b0;
        auto_rv  = 1'b0;
        if (auto_pend) begin
            auto_pend  = 1'b0;
            auto_rv    = 1'b1;
            auto_rdata = rd_of(auto_addr);
        end else if (bus.m_req === 1'b1) begin
            auto_gnt  = 1'b1;
            auto_addr = bus.m_addr;
            auto_pend = 1'b1;
        end
    end

    // Reference model: at most one transaction in flight, tracked as granted/accepted flags.
    bit          mdl_have = 0, mdl_acc = 0, mdl_is_d = 0, mdl_we = 0;
    logic [31:0] mdl_addr = '0, mdl_wdata = '0;
    logic [3:0]  mdl_be = '0;
    int          mdl_streak = 0, mdl_age = 0;

    function automatic bit mdl_done();
        return mdl_have && (bus.m_rvalid === 1'b1) && (mdl_acc || (bus.m_gnt === 1'b1));
    endfunction

    function automatic bit mdl_abort();
`ifdef HOLY_ARB_TIMEOUT_EN
        return mdl_have && !mdl_done() && (mdl_age == TMO - 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit mdl_pick_d();
        return bus.d_req && (!bus.i_req || (mdl_streak < MAX_D));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mdl_have <= 0; mdl_acc <= 0; mdl_is_d <= 0; mdl_we <= 0;
            mdl_addr <= '0; mdl_wdata <= '0; mdl_be <= '0;
            mdl_streak <= 0; mdl_age <= 0;
        end else if (mdl_have) begin
            if (mdl_done() || mdl_abort()) begin
                mdl_have <= 0;
                mdl_acc  <= 0;
            end else if (bus.m_gnt === 1'b1) begin
                mdl_acc <= 1;
            end
            mdl_age <= mdl_age + 1;
        end else if (bus.d_req || bus.i_req) begin
            mdl_have <= 1;
            mdl_acc  <= 0;
            mdl_age  <= 0;
            if (mdl_pick_d()) begin
                mdl_is_d   <= 1;
                mdl_we     <= bus.d_we;
                mdl_addr   <= bus.d_addr;
                mdl_wdata  <= bus.d_wdata;
                mdl_be     <= bus.d_we ? bus.d_be : 4'hF;
                mdl_streak <= bus.i_req ? ((mdl_streak < 15) ? mdl_streak + 1 : 15) : 0;
            end else begin
                mdl_is_d   <= 0;
                mdl_we     <= 0;
                mdl_addr   <= bus.i_addr;
                mdl_wdata  <= '0;
                mdl_be     <= 4'hF;
                mdl_streak <= 0;
            end
        end
    end

    always @(negedge clk) begin
        bit          resp;
        logic [31:0] rdata_exp;
        resp      = (mdl_done() || mdl_abort()) && !rst;
        rdata_exp = mdl_abort() ? 32'h0 : bus.m_rdata;
        check("m_req",   bus.m_req,   mdl_have && !mdl_acc);
        check("m_we",    bus.m_we,    mdl_we);
        check("m_addr",  bus.m_addr,  mdl_addr);
        check("m_be",    bus.m_be,    mdl_be);
        if (mdl_we) check("m_wdata", bus.m_wdata, mdl_wdata);
        check("i_valid", bus.i_valid, resp && !mdl_is_d);
        check("d_valid", bus.d_valid, resp && mdl_is_d);
        check("i_stall", bus.i_stall, bus.i_req && !(resp && !mdl_is_d));
        check("d_stall", bus.d_stall, bus.d_req && !(resp && mdl_is_d));
        check("bus_err", bus.bus_err, mdl_abort() && !rst);
        if (resp && !mdl_is_d) check("i_rdata", bus.i_rdata, rdata_exp);
        if (resp && mdl_is_d && !mdl_we) check("d_rdata", bus.d_rdata, rdata_exp);
    end

    // Log of response pulses in order, for sequence checks.
    byte order_q[$];
    always @(negedge clk) begin
        if (bus.d_valid === 1'b1) order_q.push_back("D");
        if (bus.i_valid === 1'b1) order_q.push_back("I");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input bit want_d, input int budget, input string name);
        bit seen = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((want_d ? bus.d_valid : bus.i_valid) === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check({name, "_seen"}, seen, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int    base;
        string exp_seq;
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;

        // Reset values.
        tick(); tick();
        @(negedge clk);
        check("rst_m_req",   bus.m_req,   1'b0);
        check("rst_m_we",    bus.m_we,    1'b0);
        check("rst_m_addr",  bus.m_addr,  32'h0);
        check("rst_m_wdata", bus.m_wdata, 32'h0);
        check("rst_m_be",    bus.m_be,    4'h0);
        check("rst_valids",  {bus.i_valid, bus.d_valid, bus.bus_err}, 3'b000);
        tick();
        rst = 0;
        man_mode = 0;
        tick();

        // Fetch only: 3-cycle latency.
        base = order_q.size();
        bus.i_req = 1; bus.i_addr = 32'h100;
        @(negedge clk);
        check("f_idle_m_req", bus.m_req, 1'b0);
        check("f_idle_stall", bus.i_stall, 1'b1);
        tick();
        @(negedge clk);
        check("f_m_req",  bus.m_req,  1'b1);
        check("f_m_addr", bus.m_addr, 32'h100);
        check("f_m_we",   bus.m_we,   1'b0);
        check("f_m_be",   bus.m_be,   4'hF);
        tick();
        @(negedge clk);
        check("f_i_valid", bus.i_valid, 1'b1);
        check("f_i_rdata", bus.i_rdata, 32'h00500093);
        check("f_i_stall", bus.i_stall, 1'b0);
        tick();
        bus.i_req = 0;
        repeat (3) tick();
        check("f_pulses", order_q.size() - base, 1);

        // Contention: data store goes first, fetch after d_valid.
        base = order_q.size();
        bus.i_req = 1; bus.i_addr = 32'h300;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'h3;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("c_d_m_we",    bus.m_we,    1'b1);
        check("c_d_m_addr",  bus.m_addr,  32'h2000);
        check("c_d_m_be",    bus.m_be,    4'h3);
        check("c_d_m_wdata", bus.m_wdata, 32'hDEADBEEF);
        wait_pulse(1, 8, "c_d_valid");
        tick();
        bus.d_req = 0; bus.d_we = 0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("c_i_m_addr", bus.m_addr, 32'h300);
        check("c_i_m_we",   bus.m_we,   1'b0);
        check("c_i_m_be",   bus.m_be,   4'hF);
        wait_pulse(0, 8, "c_i_valid");
        tick();
        bus.i_req = 0;
        check("c_first",  order_q[base],     "D");
        check("c_second", order_q[base + 1], "I");

        // Starvation: both held, 4 data then 1 fetch, repeating.
        tick();
        base = order_q.size();
        exp_seq = "DDDDIDDDDI";
        bus.i_req = 1; bus.i_addr = 32'h400;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h3000; bus.d_be = 4'h0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (order_q.size() - base >= 10) break;
        end
        tick();
        bus.i_req = 0; bus.d_req = 0;
        check("s_count", order_q.size() - base, 10);
        for (int k = 0; k < 10; k++) begin
            if (base + k < order_q.size()) check($sformatf("s_seq%0d", k), order_q[base + k], exp_seq[k]);
        end
        repeat (2) tick();

        // Delayed handshakes: grant after 5 ISSUE cycles, spurious rvalid in ISSUE, rvalid 3 after grant.
        man_mode = 1; man_gnt = 0; man_rv = 0;
        base = order_q.size();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h5000;
        @(negedge clk);
        tick();
        for (int k = 0; k < 5; k++) begin
            man_rv = (k == 2); man_rdata = 32'hBAD0BAD0;
            @(negedge clk);
            check($sformatf("h_m_req%0d", k),  bus.m_req,  1'b1);
            check($sformatf("h_m_addr%0d", k), bus.m_addr, 32'h5000);
            check($sformatf("h_no_dv%0d", k),  bus.d_valid, 1'b0);
            tick();
        end
        man_rv = 0; man_gnt = 1;
        @(negedge clk);
        check("h_gnt_m_req", bus.m_req, 1'b1);
        tick();
        man_gnt = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("h_wait_m_req%0d", k), bus.m_req, 1'b0);
            check($sformatf("h_wait_dv%0d", k),    bus.d_valid, 1'b0);
            tick();
        end
        man_rv = 1; man_rdata = 32'h12345678;
        @(negedge clk);
        check("h_d_valid", bus.d_valid, 1'b1);
        check("h_d_rdata", bus.d_rdata, 32'h12345678);
        tick();
        man_rv = 0; bus.d_req = 0;
        repeat (3) tick();
        check("h_pulses", order_q.size() - base, 1);

        // Reset in WAIT, then a stale rvalid right after reset.
        base = order_q.size();
        bus.i_req = 1; bus.i_addr = 32'h600;
        @(negedge clk);
        tick();
        man_gnt = 1;
        @(negedge clk);
        tick();
        man_gnt = 0;
        @(negedge clk);
        check("r_wait_m_req", bus.m_req, 1'b0);
        tick();
        rst = 1; bus.i_req = 0;
        tick();
        rst = 0; man_rv = 1; man_rdata = 32'h0000CAFE;
        @(negedge clk);
        check("r_no_valid", {bus.i_valid, bus.d_valid}, 2'b00);
        check("r_m_req",    bus.m_req, 1'b0);
        tick();
        man_rv = 0; man_mode = 0;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h700; bus.d_wdata = 32'h11; bus.d_be = 4'hC;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("r_new_m_req",  bus.m_req,  1'b1);
        check("r_new_m_addr", bus.m_addr, 32'h700);
        check("r_new_m_be",   bus.m_be,   4'hC);
        wait_pulse(1, 8, "r_new_d_valid");
        tick();
        bus.d_req = 0; bus.d_we = 0;
        repeat (2) tick();
        check("r_pulses", order_q.size() - base, 1);

`ifdef HOLY_ARB_TIMEOUT_EN
        // Watchdog: no grant ever, abort on the 8th ISSUE cycle; late rvalid ignored.
        man_mode = 1; man_gnt = 0; man_rv = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h800;
        @(negedge clk);
        tick();
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            check($sformatf("t_bus_err%0d", k), bus.bus_err, (k == TMO));
            check($sformatf("t_d_valid%0d", k), bus.d_valid, (k == TMO));
            check($sformatf("t_m_req%0d", k),   bus.m_req,   1'b1);
            if (k == TMO) check("t_d_rdata", bus.d_rdata, 32'h0);
            tick();
        end
        bus.d_req = 0; man_rv = 1; man_rdata = 32'h55AA55AA;
        @(negedge clk);
        check("t_late_dv",  bus.d_valid, 1'b0);
        check("t_late_err", bus.bus_err, 1'b0);
        check("t_m_req_lo", bus.m_req,   1'b0);
        tick();
        man_rv = 0;
        repeat (2) tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-outstanding memory port between instruction fetch and data load/store.
- Sits between the fetch stage, the load/store path (driven by the decoder's mem_read/mem_write), and the external memory/bus adapter.
- Arbitrates with data priority plus an anti-starvation streak limit.
- Sequences each transaction through issue/accept/response, and returns per-requester valid and stall signals to the core.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch is waiting; range 1..15.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_req  in  1  fetch request; held high until i_valid.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch data.
- i_valid  out  1  one-cycle fetch response pulse.
- i_stall  out  1  i_req & ~i_valid.
- d_req  in  1  data request (mem_read|mem_write); held until d_valid.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_rdata  out  DATA_W  load data.
- d_valid  out  1  one-cycle data response pulse.
- d_stall  out  1  d_req & ~d_valid.
- m_req  out  1  memory request, registered.
- m_we  out  1  memory write.
- m_addr  out  ADDR_W  memory address, registered.
- m_wdata  out  DATA_W  memory write data.
- m_be  out  DATA_W/8  memory byte enables; all ones for reads.
- m_gnt  in  1  memory accepts the request when m_req & m_gnt.
- m_rvalid  in  1  response or write acknowledge.
- m_rdata  in  DATA_W  read data.
- bus_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset values:
  - state IDLE, owner NONE, streak 0.
  - m_req, m_we, i_valid, d_valid and bus_err all 0.
  - m_addr, m_wdata and m_be 0.
  - Reset is honoured mid-transaction: outstanding state is dropped.
- States:
  - IDLE: no transaction in flight.
  - ISSUE: m_req high, waiting for m_gnt.
  - WAIT: accepted, waiting for m_rvalid.
- IDLE arbitration:
  - If d_req and (~i_req or streak < MAX_D_STREAK): grant data.
  - Else if i_req: grant fetch.
  - Latch owner, we, addr, wdata and be into the m_* registers, then go to ISSUE. m_req rises the next cycle.
- ISSUE:
  - m_req and the request fields are held stable until m_gnt.
  - On m_gnt: m_req drops, go to WAIT.
  - If m_rvalid arrives in the same cycle as m_gnt, go straight to IDLE and respond as in WAIT.
- WAIT:
  - On m_rvalid: pulse the owner's valid in the same cycle; i_rdata/d_rdata = m_rdata, combinational passthrough.
  - Go to IDLE.
  - Writes also complete on m_rvalid; d_rdata is don't-care for stores.
- Streak counter:
  - Data grant while i_req is high: streak+1, saturating.
  - Any fetch grant: streak cleared.
  - Data grant with i_req low: streak held at 0.
- Minimum latency, request to valid: 3 cycles (IDLE → ISSUE with m_gnt → WAIT with m_rvalid). Back-to-back throughput is one transaction per 3 cycles.
- Ignored inputs:
  - m_rvalid in IDLE or ISSUE without m_gnt is ignored and generates no valid.
  - m_gnt outside ISSUE is ignored.
- Requester rules:
  - A requester that drops its req before valid is a protocol violation.
  - The transaction still completes and its response is still pulsed.
- Simultaneous events: a new request arriving in the same cycle as a response is arbitrated only in the following IDLE cycle. There is no same-cycle re-issue.

Optional Feature:
- Macro: HOLY_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in ISSUE and WAIT and clears on entering IDLE.
  - After TIMEOUT_CYCLES cycles without completion: force m_req=0, pulse the owner's valid with rdata=0, pulse bus_err, return to IDLE.
  - A late m_rvalid after the abort is ignored.
- Undefined: no counter; bus_err is tied 0; a transaction may wait indefinitely.

Decomposition:
- Shared package holy_core_pkg gets:
  - arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT}.
  - arb_owner_t {ARB_OWNER_NONE, ARB_OWNER_I, ARB_OWNER_D}.
  - Default constants for MAX_D_STREAK and TIMEOUT_CYCLES.
- Sub-module arb_watchdog: a resettable saturating counter with clear, enable and expire, instantiated only under HOLY_ARB_TIMEOUT_EN. Everything else stays in one module.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100, m_gnt=1 in ISSUE, m_rvalid=1 with m_rdata=0x00500093 one cycle later → m_addr=0x100, m_we=0, m_be=0xF; i_valid pulses once with i_rdata=0x00500093; i_stall low in that cycle.
- Contention: i_req and d_req both rise in the same IDLE cycle, with d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0x3 → data issued first with m_we=1, m_be=0x3; fetch issued after d_valid.
- Starvation: d_req held continuously with i_req held, MAX_D_STREAK=4 → exactly 4 data transactions, then 1 fetch, then data resumes with streak reset.
- Delayed handshakes: m_gnt held 0 for 5 cycles, then m_rvalid 3 cycles after m_gnt → m_req and m_addr stable for all 5 cycles; a spurious m_rvalid during ISSUE produces no valid; exactly one d_valid.
- Reset mid-transaction: rst asserted in WAIT, then m_rvalid the cycle after rst deasserts → no i_valid/d_valid pulse; m_req=0; a new request is granted normally.
- With HOLY_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: m_gnt never asserted → on the 8th cycle of ISSUE, bus_err and d_valid pulse with d_rdata=0, m_req drops, state returns to IDLE.
